// File: rtl/ysyx_22050612_mem_pkg.sv
// Shared types for the IFU/LSU memory arbiter: FSM states, owner encoding,
// default channel widths and the latched downstream request record.
package ysyx_22050612_mem_pkg;

  localparam int MEM_ADDR_W = 64;
  localparam int MEM_DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  typedef struct packed {
    logic                    wen;
    logic [MEM_ADDR_W-1:0]   addr;
    logic [MEM_DATA_W-1:0]   wdata;
    logic [MEM_DATA_W/8-1:0] wmask;
  } mem_req_t;

endpackage

// File: rtl/ysyx_22050612_wdog_counter.sv
// WAIT-state watchdog: counts enabled cycles and flags expiry on the
// TIMEOUT_CYC-th one; TIMEOUT_CYC = 0 never expires.
module ysyx_22050612_wdog_counter #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT_CYC > 0) ? CW'(TIMEOUT_CYC - 1) : '0;

  logic [CW-1:0] r_cnt;

  assign o_expire = (TIMEOUT_CYC != 0) && i_en && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expire) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ysyx_22050612_mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between IFU and LSU.
// Define ARB_ROUND_ROBIN_EN for alternating grants on contention (default: LSU priority).
module ysyx_22050612_mem_arbiter
  import ysyx_22050612_mem_pkg::*;
#(
  parameter int ADDR_W      = MEM_ADDR_W,
  parameter int DATA_W      = MEM_DATA_W,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_resp_valid,
  output logic [DATA_W-1:0]   if_resp_rdata,
  output logic                if_resp_err,
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic                ls_req_wen,
  input  logic [ADDR_W-1:0]   ls_req_addr,
  input  logic [DATA_W-1:0]   ls_req_wdata,
  input  logic [DATA_W/8-1:0] ls_req_wmask,
  output logic                ls_resp_valid,
  output logic [DATA_W-1:0]   ls_resp_rdata,
  output logic                ls_resp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_wen,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_rdata
);

  state_e            r_state, w_state_nxt;
  owner_e            r_owner;
  mem_req_t          r_req;
  logic              w_grant_ls, w_acc_if, w_acc_ls;
  logic              w_expire, w_done;
  logic [DATA_W-1:0] w_rdata;
  logic              r_if_resp_valid, r_if_resp_err;
  logic              r_ls_resp_valid, r_ls_resp_err;
  logic [DATA_W-1:0] r_if_resp_rdata, r_ls_resp_rdata;

`ifdef ARB_ROUND_ROBIN_EN
  owner_e r_last_owner;

  // Under contention the side that was not served last time wins.
  always_comb w_grant_ls = ls_req_valid && (!if_req_valid || (r_last_owner == OWN_IF));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_owner <= OWN_IF;
    end else if (w_acc_ls) begin
      r_last_owner <= OWN_LS;
    end else if (w_acc_if) begin
      r_last_owner <= OWN_IF;
    end
  end
`else
  always_comb w_grant_ls = ls_req_valid;
`endif

  always_comb begin
    if_req_ready = (r_state == IDLE) && if_req_valid && !w_grant_ls;
    ls_req_ready = (r_state == IDLE) && w_grant_ls;
    w_acc_if     = if_req_valid && if_req_ready;
    w_acc_ls     = ls_req_valid && ls_req_ready;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_acc_if || w_acc_ls) w_state_nxt = ISSUE;
      ISSUE:   if (mem_req_ready) w_state_nxt = WAIT;
      WAIT:    if (mem_resp_valid || w_expire) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // IFU requests carry no write payload, so those fields are zeroed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner <= OWN_IF;
      r_req   <= '0;
    end else if (w_acc_ls) begin
      r_owner     <= OWN_LS;
      r_req.wen   <= ls_req_wen;
      r_req.addr  <= ls_req_addr;
      r_req.wdata <= ls_req_wdata;
      r_req.wmask <= ls_req_wmask;
    end else if (w_acc_if) begin
      r_owner     <= OWN_IF;
      r_req.wen   <= 1'b0;
      r_req.addr  <= if_req_addr;
      r_req.wdata <= '0;
      r_req.wmask <= '0;
    end
  end

  ysyx_22050612_wdog_counter #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (r_state != WAIT),
    .i_en     ((r_state == WAIT) && !mem_resp_valid),
    .o_expire (w_expire)
  );

  // A response that races the watchdog wins; stray responses outside WAIT are dropped.
  always_comb begin
    w_done  = (r_state == WAIT) && (mem_resp_valid || w_expire);
    w_rdata = mem_resp_valid ? mem_resp_rdata : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_resp_valid <= 1'b0;
      r_if_resp_err   <= 1'b0;
      r_if_resp_rdata <= '0;
      r_ls_resp_valid <= 1'b0;
      r_ls_resp_err   <= 1'b0;
      r_ls_resp_rdata <= '0;
    end else begin
      r_if_resp_valid <= w_done && (r_owner == OWN_IF);
      r_if_resp_err   <= w_done && (r_owner == OWN_IF) && w_expire;
      r_ls_resp_valid <= w_done && (r_owner == OWN_LS);
      r_ls_resp_err   <= w_done && (r_owner == OWN_LS) && w_expire;
      if (w_done && (r_owner == OWN_IF)) begin
        r_if_resp_rdata <= w_rdata;
      end
      if (w_done && (r_owner == OWN_LS)) begin
        r_ls_resp_rdata <= r_req.wen ? '0 : w_rdata;
      end
    end
  end

  assign if_resp_valid = r_if_resp_valid;
  assign if_resp_err   = r_if_resp_err;
  assign if_resp_rdata = r_if_resp_rdata;
  assign ls_resp_valid = r_ls_resp_valid;
  assign ls_resp_err   = r_ls_resp_err;
  assign ls_resp_rdata = r_ls_resp_rdata;

  assign mem_req_valid = (r_state == ISSUE);
  assign mem_req_wen   = r_req.wen;
  assign mem_req_addr  = r_req.addr;
  assign mem_req_wdata = r_req.wdata;
  assign mem_req_wmask = r_req.wmask;

endmodule

// File: tb/tb_ysyx_22050612_mem_arbiter.sv
// Scoreboard bench for ysyx_22050612_mem_arbiter (TIMEOUT_CYC = 4); expectations
// follow ARB_ROUND_ROBIN_EN when it is defined.
module tb_ysyx_22050612_mem_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req_valid, if_req_ready;
  logic [AW-1:0] if_req_addr;
  logic          if_resp_valid, if_resp_err;
  logic [DW-1:0] if_resp_rdata;
  logic          ls_req_valid, ls_req_ready, ls_req_wen;
  logic [AW-1:0] ls_req_addr;
  logic [DW-1:0] ls_req_wdata;
  logic [7:0]    ls_req_wmask;
  logic          ls_resp_valid, ls_resp_err;
  logic [DW-1:0] ls_resp_rdata;
  logic          mem_req_valid, mem_req_ready, mem_req_wen;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata;
  logic [7:0]    mem_req_wmask;
  logic          mem_resp_valid;
  logic [DW-1:0] mem_resp_rdata;

  logic mem_auto;
  logic inject_stray;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  typedef struct { logic [63:0] rdata; logic err; int cyc; } resp_t;
  typedef struct { logic wen; logic [63:0] addr; logic [63:0] wdata; logic [7:0] wmask; logic full; } mreq_t;

  resp_t if_q[$];
  resp_t ls_q[$];
  mreq_t mq[$];

  ysyx_22050612_mem_arbiter #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .TIMEOUT_CYC (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_req_valid   (if_req_valid),
    .if_req_ready   (if_req_ready),
    .if_req_addr    (if_req_addr),
    .if_resp_valid  (if_resp_valid),
    .if_resp_rdata  (if_resp_rdata),
    .if_resp_err    (if_resp_err),
    .ls_req_valid   (ls_req_valid),
    .ls_req_ready   (ls_req_ready),
    .ls_req_wen     (ls_req_wen),
    .ls_req_addr    (ls_req_addr),
    .ls_req_wdata   (ls_req_wdata),
    .ls_req_wmask   (ls_req_wmask),
    .ls_resp_valid  (ls_resp_valid),
    .ls_resp_rdata  (ls_resp_rdata),
    .ls_resp_err    (ls_resp_err),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_wen    (mem_req_wen),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_wmask  (mem_req_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] mem_data(input logic [63:0] a);
    if (a == 64'h8000_0000) return 64'h0010_0073;
    return a ^ 64'hA5A5_0000_0000_0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model: answers the cycle after a handshake when mem_auto is set.
  initial begin : mem_model
    logic        hs;
    logic [63:0] a;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    forever begin
      @(negedge clk);
      hs = mem_req_valid && mem_req_ready;
      a  = mem_req_addr;
      @(posedge clk); #1;
      mem_resp_valid = (hs && mem_auto) || inject_stray;
      mem_resp_rdata = (hs && mem_auto) ? mem_data(a) : (inject_stray ? 64'hDEAD_BEEF : 64'h0);
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a response or request.
  initial begin : monitor
    resp_t e;
    mreq_t m;
    forever begin
      @(negedge clk);
      if (if_resp_valid) begin
        if (if_q.size() == 0) check("if_unexpected_resp", 64'(if_resp_valid), 64'd0);
        else begin
          e = if_q.pop_front();
          check("if_rdata", if_resp_rdata, e.rdata);
          check("if_err", 64'(if_resp_err), 64'(e.err));
          if (e.cyc >= 0) check("if_latency", 64'(cyc), 64'(e.cyc));
        end
      end
      if (ls_resp_valid) begin
        if (ls_q.size() == 0) check("ls_unexpected_resp", 64'(ls_resp_valid), 64'd0);
        else begin
          e = ls_q.pop_front();
          check("ls_rdata", ls_resp_rdata, e.rdata);
          check("ls_err", 64'(ls_resp_err), 64'(e.err));
          if (e.cyc >= 0) check("ls_latency", 64'(cyc), 64'(e.cyc));
        end
      end
      if (mem_req_valid && mem_req_ready) begin
        if (mq.size() == 0) check("mem_unexpected_req", 64'(mem_req_valid), 64'd0);
        else begin
          m = mq.pop_front();
          check("mem_wen", 64'(mem_req_wen), 64'(m.wen));
          check("mem_addr", mem_req_addr, m.addr);
          if (m.full) begin
            check("mem_wdata", mem_req_wdata, m.wdata);
            check("mem_wmask", 64'(mem_req_wmask), 64'(m.wmask));
          end
        end
      end
    end
  end

  task automatic req_if(input logic [63:0] addr, output int acc);
    acc = -1;
    if_req_valid = 1'b1;
    if_req_addr  = addr;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (if_req_ready) begin
        acc = cyc;
        break;
      end
    end
    @(posedge clk); #1;
    if_req_valid = 1'b0;
    if_req_addr  = '0;
    if (acc < 0) check("if_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic req_ls(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [7:0] wmask, output int acc);
    acc = -1;
    ls_req_valid = 1'b1;
    ls_req_wen   = wen;
    ls_req_addr  = addr;
    ls_req_wdata = wdata;
    ls_req_wmask = wmask;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (ls_req_ready) begin
        acc = cyc;
        break;
      end
    end
    @(posedge clk); #1;
    ls_req_valid = 1'b0;
    ls_req_wen   = 1'b0;
    ls_req_addr  = '0;
    ls_req_wdata = '0;
    ls_req_wmask = '0;
    if (acc < 0) check("ls_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 60; n++) begin
      @(posedge clk); #1;
      if (if_q.size() == 0 && ls_q.size() == 0 && mq.size() == 0) break;
    end
    check(name, 64'(if_q.size() + ls_q.size() + mq.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic stray_pulse();
    inject_stray = 1'b1;
    @(posedge clk); #3;
    inject_stray = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("stray_if_quiet", 64'(if_resp_valid), 64'd0);
      check("stray_ls_quiet", 64'(ls_resp_valid), 64'd0);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_req_valid"}, 64'(mem_req_valid), 64'd0);
    check({tag, "_mem_req_wen"}, 64'(mem_req_wen), 64'd0);
    check({tag, "_mem_req_addr"}, mem_req_addr, 64'd0);
    check({tag, "_mem_req_wdata"}, mem_req_wdata, 64'd0);
    check({tag, "_mem_req_wmask"}, 64'(mem_req_wmask), 64'd0);
    check({tag, "_if_resp_valid"}, 64'(if_resp_valid), 64'd0);
    check({tag, "_if_resp_err"}, 64'(if_resp_err), 64'd0);
    check({tag, "_if_resp_rdata"}, if_resp_rdata, 64'd0);
    check({tag, "_ls_resp_valid"}, 64'(ls_resp_valid), 64'd0);
    check({tag, "_ls_resp_err"}, 64'(ls_resp_err), 64'd0);
    check({tag, "_ls_resp_rdata"}, ls_resp_rdata, 64'd0);
    check({tag, "_if_req_ready"}, 64'(if_req_ready), 64'd0);
    check({tag, "_ls_req_ready"}, 64'(ls_req_ready), 64'd0);
  endtask

  initial begin : stim
    int c, acc_i, acc_l;
    rst_n = 1'b0;
    if_req_valid = 1'b0; if_req_addr = '0;
    ls_req_valid = 1'b0; ls_req_wen = 1'b0; ls_req_addr = '0;
    ls_req_wdata = '0; ls_req_wmask = '0;
    mem_req_ready = 1'b1;
    mem_auto = 1'b1;
    inject_stray = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic IFU fetch, immediate memory.
    c = cyc;
    mq.push_back('{wen: 1'b0, addr: 64'h8000_0000, wdata: 64'h0, wmask: 8'h0, full: 1'b0});
    if_q.push_back('{rdata: 64'h0010_0073, err: 1'b0, cyc: c + 3});
    req_if(64'h8000_0000, acc_i);
    check("if_accept_cycle", 64'(acc_i), 64'(c));
    drain("drain_basic");

    // Contention: LSU write wins, IFU granted as ls_resp_valid pulses.
    c = cyc;
    mq.push_back('{wen: 1'b1, addr: 64'h8000_1000, wdata: 64'hAB, wmask: 8'h01, full: 1'b1});
    mq.push_back('{wen: 1'b0, addr: 64'h8000_2000, wdata: 64'h0, wmask: 8'h0, full: 1'b0});
    ls_q.push_back('{rdata: 64'h0, err: 1'b0, cyc: c + 3});
    if_q.push_back('{rdata: mem_data(64'h8000_2000), err: 1'b0, cyc: c + 6});
    fork
      req_ls(1'b1, 64'h8000_1000, 64'hAB, 8'h01, acc_l);
      req_if(64'h8000_2000, acc_i);
    join
    check("cont1_ls_accept", 64'(acc_l), 64'(c));
    check("cont1_if_accept", 64'(acc_i), 64'(c + 3));
    drain("drain_cont1");

    // LSU-only read, then a second contention.
    mq.push_back('{wen: 1'b0, addr: 64'h8000_1008, wdata: 64'h0, wmask: 8'hFF, full: 1'b1});
    ls_q.push_back('{rdata: mem_data(64'h8000_1008), err: 1'b0, cyc: cyc + 3});
    req_ls(1'b0, 64'h8000_1008, 64'h0, 8'hFF, acc_l);
    drain("drain_ls_read");

    c = cyc;
`ifdef ARB_ROUND_ROBIN_EN
    mq.push_back('{wen: 1'b0, addr: 64'h8000_2004, wdata: 64'h0, wmask: 8'h0, full: 1'b0});
    mq.push_back('{wen: 1'b1, addr: 64'h8000_1010, wdata: 64'h55, wmask: 8'h02, full: 1'b1});
    if_q.push_back('{rdata: mem_data(64'h8000_2004), err: 1'b0, cyc: c + 3});
    ls_q.push_back('{rdata: 64'h0, err: 1'b0, cyc: c + 6});
`else
    mq.push_back('{wen: 1'b1, addr: 64'h8000_1010, wdata: 64'h55, wmask: 8'h02, full: 1'b1});
    mq.push_back('{wen: 1'b0, addr: 64'h8000_2004, wdata: 64'h0, wmask: 8'h0, full: 1'b0});
    ls_q.push_back('{rdata: 64'h0, err: 1'b0, cyc: c + 3});
    if_q.push_back('{rdata: mem_data(64'h8000_2004), err: 1'b0, cyc: c + 6});
`endif
    fork
      req_ls(1'b1, 64'h8000_1010, 64'h55, 8'h02, acc_l);
      req_if(64'h8000_2004, acc_i);
    join
`ifdef ARB_ROUND_ROBIN_EN
    check("cont2_if_accept", 64'(acc_i), 64'(c));
    check("cont2_ls_accept", 64'(acc_l), 64'(c + 3));
`else
    check("cont2_ls_accept", 64'(acc_l), 64'(c));
    check("cont2_if_accept", 64'(acc_i), 64'(c + 3));
`endif
    drain("drain_cont2");

    // Downstream stall: fields stable, upstream readys low while LSU waits.
    mem_req_ready = 1'b0;
    mq.push_back('{wen: 1'b0, addr: 64'h8000_3000, wdata: 64'h0, wmask: 8'h0, full: 1'b0});
    if_q.push_back('{rdata: mem_data(64'h8000_3000), err: 1'b0, cyc: -1});
    req_if(64'h8000_3000, acc_i);
    ls_req_valid = 1'b1; ls_req_wen = 1'b0; ls_req_addr = 64'h8000_4000;
    ls_req_wdata = '0; ls_req_wmask = 8'hFF;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("stall_mem_valid", 64'(mem_req_valid), 64'd1);
      check("stall_mem_addr", mem_req_addr, 64'h8000_3000);
      check("stall_mem_wen", 64'(mem_req_wen), 64'd0);
      check("stall_if_ready", 64'(if_req_ready), 64'd0);
      check("stall_ls_ready", 64'(ls_req_ready), 64'd0);
    end
    @(posedge clk); #1;
    mem_req_ready = 1'b1;
    mq.push_back('{wen: 1'b0, addr: 64'h8000_4000, wdata: 64'h0, wmask: 8'hFF, full: 1'b1});
    ls_q.push_back('{rdata: mem_data(64'h8000_4000), err: 1'b0, cyc: -1});
    req_ls(1'b0, 64'h8000_4000, 64'h0, 8'hFF, acc_l);
    drain("drain_stall");

    // Timeout: no memory response, then a late stray response in IDLE.
    mem_auto = 1'b0;
    c = cyc;
    mq.push_back('{wen: 1'b0, addr: 64'h8000_5000, wdata: 64'h0, wmask: 8'hFF, full: 1'b1});
    ls_q.push_back('{rdata: 64'h0, err: 1'b1, cyc: c + 6});
    req_ls(1'b0, 64'h8000_5000, 64'h0, 8'hFF, acc_l);
    drain("drain_timeout");
    stray_pulse();

    // Reset in WAIT, stray afterwards, then a normal fetch.
    mq.push_back('{wen: 1'b0, addr: 64'h8000_6000, wdata: 64'h0, wmask: 8'h0, full: 1'b0});
    req_if(64'h8000_6000, acc_i);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    stray_pulse();
    mem_auto = 1'b1;
    c = cyc;
    mq.push_back('{wen: 1'b0, addr: 64'h8000_0000, wdata: 64'h0, wmask: 8'h0, full: 1'b0});
    if_q.push_back('{rdata: 64'h0010_0073, err: 1'b0, cyc: c + 3});
    req_if(64'h8000_0000, acc_i);
    check("post_reset_accept", 64'(acc_i), 64'(c));
    drain("drain_post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1, "bench did not finish");
  end

endmodule

// File: doc/ysyx_22050612_mem_arbiter.md
Name: ysyx_22050612_mem_arbiter

Overview:
- Shares the single physical memory port between the instruction-fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Replaces the combinational DPI pmem_read/pmem_write access in the execute unit with a multi-cycle valid/ready request channel plus a response channel.
- Only one transaction is outstanding at a time; each response is routed back to the requester that was granted.
- Sits between IFU/LSU and the memory/bus bridge.

Parameters:
- ADDR_W, 64, address width of all channels.
- DATA_W, 64, data width; the write mask is DATA_W/8 bits.
- TIMEOUT_CYC, 255, number of WAIT cycles before an error response is returned; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req_valid  in  1  IFU read request.
- if_req_ready  out  1  IFU request accepted this cycle.
- if_req_addr  in  ADDR_W  IFU fetch address.
- if_resp_valid  out  1  one-cycle IFU response pulse.
- if_resp_rdata  out  DATA_W  IFU read data.
- if_resp_err  out  1  IFU response is a timeout error.
- ls_req_valid  in  1  LSU request.
- ls_req_ready  out  1  LSU request accepted this cycle.
- ls_req_wen  in  1  1 = write, 0 = read.
- ls_req_addr  in  ADDR_W  LSU address.
- ls_req_wdata  in  DATA_W  write data, already lane-aligned.
- ls_req_wmask  in  DATA_W/8  byte enables.
- ls_resp_valid  out  1  one-cycle LSU response pulse (also acknowledges writes).
- ls_resp_rdata  out  DATA_W  LSU read data (0 for writes).
- ls_resp_err  out  1  LSU response is a timeout error.
- mem_req_valid, mem_req_ready  out/in  1  downstream request handshake.
- mem_req_wen / mem_req_addr / mem_req_wdata / mem_req_wmask  out  1/ADDR_W/DATA_W/DATA_W/8  latched request fields.
- mem_resp_valid  in  1  downstream response strobe; there is no backpressure.
- mem_resp_rdata  in  DATA_W  downstream read data.

Behaviour:
- Reset:
  - State = IDLE.
  - All *_valid, *_ready, *_err outputs = 0; data, address and mask outputs = 0.
  - Owner = IFU; timeout counter = 0.
- FSM IDLE -> ISSUE -> WAIT -> IDLE.
- IDLE:
  - Grant is combinational: LSU has priority over IFU.
  - The granted requester's ready = 1; the other's ready = 0.
  - On valid&&ready: latch owner and request fields into the mem_req_* registers, go to ISSUE.
  - With no valid request: stay in IDLE.
- ISSUE:
  - mem_req_valid = 1; fields are held stable until mem_req_ready.
  - On mem_req_valid&&mem_req_ready: go to WAIT with counter = 0.
- WAIT:
  - On mem_resp_valid: register rdata into the owner's resp_rdata (forced to 0 for writes). The owner's resp_valid pulses for exactly one cycle on the next cycle with err = 0. Return to IDLE on that same edge.
  - Otherwise the counter increments. When counter == TIMEOUT_CYC-1 and TIMEOUT_CYC != 0: owner resp_valid = 1, err = 1, rdata = 0; go to IDLE.
- Latency:
  - Request acceptance to mem_req_valid: 1 cycle.
  - mem_resp_valid to requester resp_valid: 1 cycle.
  - Minimum round trip: 3 cycles from acceptance when mem_req_ready and the response are immediate. A new request can be accepted in the same cycle resp_valid is high.
- Upstream readys are 0 in ISSUE and WAIT.
- A mem_resp_valid seen in IDLE or ISSUE is a stray response from a prior timeout or a pre-reset transaction. It is ignored and produces no upstream response.
- Simultaneous if/ls valid in IDLE: LSU wins; IFU waits, and its request must stay stable while unaccepted.
- Reset mid-transaction: mem_req_valid drops immediately (asynchronous) and the transaction is discarded without a response.
- The arbiter does not split or check alignment.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: on contention, the requester not served in the last grant wins, using a one-bit last-owner register (reset = IFU, so the LSU wins the first contention). Without contention, the sole requester is granted.
- Undefined: fixed LSU > IFU priority; the last-owner register is absent.

Decomposition:
- Package ysyx_22050612_mem_pkg holds:
  - the state enum (IDLE/ISSUE/WAIT);
  - the owner enum (OWN_IF/OWN_LS);
  - default ADDR_W/DATA_W constants;
  - a request struct {wen, addr, wdata, wmask}.
- Sub-module ysyx_22050612_wdog_counter: clear/enable/expire output, parameterised by TIMEOUT_CYC.

Test Plan:
- IFU read of addr 0x80000000, mem ready and response immediate, rdata 0x00100073 -> if_resp_valid exactly 3 cycles after acceptance, data 0x00100073, err 0.
- IFU and LSU valid in the same IDLE cycle, LSU write 0x80001000 wdata 0xAB wmask 0x01 -> LSU granted first, mem_req_wen = 1, ls_resp_rdata = 0; IFU granted in the cycle ls_resp_valid is high. With ARB_ROUND_ROBIN_EN, a second contention grants the IFU.
- mem_req_ready held low for 5 cycles -> mem_req_valid and fields stable for all 5 cycles, upstream readys 0 throughout.
- TIMEOUT_CYC = 4, no mem_resp_valid -> owner resp_valid with err = 1, rdata 0 after 4 WAIT cycles. A late mem_resp_valid in IDLE -> no upstream pulse.
- rst_n asserted during WAIT -> all outputs 0 asynchronously; a following mem_resp_valid is ignored; the next IFU request completes normally.
